uart_mem_loader: RTL and testbench
==================================

// Module: uart_mem_loader
// PURPOSE
//  Sits between uart_rx/uart_tx and the CPU's instruction/data memories. Load mode
//  assembles received bytes into 32-bit words and writes them to IM or DM at
//  sequential word addresses. Dump mode reads DM/IM words and streams them out
//  byte-wise on UART TX. Drives the IM_Done/DM_Done LEDs. Active only while uart_on=1.
// PARAMETERS
//  ADDR_W         8   word-address width of mem_addr
//  IM_LOAD_WORDS  10  words written to IM before im_done sets (1..2^ADDR_W)
//  DM_LOAD_WORDS  3   words written to DM before dm_done sets (1..2^ADDR_W)
//  DUMP_WORDS     3   words read and transmitted per dump session (1..2^ADDR_W)
// PORTS
//  clk          in   1       system clock (100 MHz)
//  reset        in   1       async, active-low; 0 = reset
//  uart_on      in   1       session enable; 1 = loader owns memories
//  uart_mode    in   1       0 = load (RX->mem), 1 = dump (mem->TX)
//  uart_ram_id  in   1       0 = IM, 1 = DM
//  rx_data      in   8       received byte from uart_rx
//  rx_valid     in   1       1-cycle strobe: rx_data valid
//  tx_busy      in   1       uart_tx busy; rises the cycle after tx_start
//  tx_data      out  8       byte to transmit
//  tx_start     out  1       1-cycle strobe to uart_tx
//  mem_sel      out  1       target memory (latched uart_ram_id)
//  mem_we       out  1       1-cycle write strobe
//  mem_re       out  1       1-cycle read strobe
//  mem_addr     out  ADDR_W  word address
//  mem_wdata    out  32      write data
//  mem_rdata    in   32      read data, valid the cycle after mem_re
//  im_done      out  1       IM load complete (led[7])
//  dm_done      out  1       DM load complete (led[6])
//  dump_done    out  1       dump session complete
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, state IDLE, byte_cnt=0, word_cnt=0.
//  FSM: IDLE, LOAD, WRITE, LOAD_END, RD, LATCH, SEND, TXWAIT, DUMP_END.
//  IDLE: when uart_on=1, latch uart_mode/uart_ram_id into mode_q/mem_sel, clear
//   word_cnt/byte_cnt; mode_q=0 -> LOAD and clear the selected done flag; mode_q=1
//   -> RD, clear dump_done. mode/ram_id changes mid-session are ignored.
//  Any state: uart_on=0 -> IDLE next cycle; partial word discarded, no strobes
//   issued; done flags hold their value.
//  LOAD: each rx_valid shifts byte into word buffer, little-endian (1st byte ->
//   [7:0], 4th -> [31:24]); byte_cnt wraps 3->0. On the 4th byte: mem_wdata<=word,
//   mem_addr<=word_cnt, go WRITE.
//  WRITE: mem_we=1 for exactly one cycle; word_cnt++. If word_cnt+1 == LOAD_WORDS
//   of mem_sel -> set im_done or dm_done, go LOAD_END; else back to LOAD.
//   An rx_valid in the WRITE cycle is captured as byte 0 of the next word.
//  LOAD_END: all rx_valid ignored; no further writes until uart_on drops.
//  RD: mem_re=1, mem_addr=word_cnt, one cycle -> LATCH: capture mem_rdata, byte_cnt=0.
//  SEND: when tx_busy=0, tx_data=byte[byte_cnt] (LSB byte first), tx_start=1 one
//   cycle -> TXWAIT (tx_busy ignored this cycle) -> when tx_busy=0: byte_cnt<3 ->
//   byte_cnt++, SEND; else word_cnt++, word_cnt==DUMP_WORDS -> dump_done=1,
//   DUMP_END, otherwise RD.
//  DUMP_END: idle, no strobes until uart_on drops.
//  mem_we, mem_re, tx_start never asserted together; each is a single-cycle pulse.
//  word_cnt is ADDR_W bits; with LOAD_WORDS = 2^ADDR_W the last address is all-ones.
// TESTING
//  1 load IM: rx bytes 0A,00,08,20 -> one mem_we, sel=0, addr=0, wdata=2008000A.
//  2 load 10 IM words -> addrs 0..9 written in order, im_done=1 after 10th write;
//    11th word's bytes produce no mem_we; dm_done stays 0.
//  3 DM load with 2 bytes sent, uart_on->0, uart_on->1, 4 bytes 78,56,34,12 ->
//    single write addr 0 data 12345678 (partial word discarded).
//  4 dump DM holding 12345678 at addr0: tx bytes 78,56,34,12 in order, each
//    tx_start only when tx_busy=0; 12 bytes total for DUMP_WORDS=3, dump_done=1.
//  5 toggle uart_ram_id mid-load -> writes keep original mem_sel.
//  6 assert reset mid-WRITE/mid-SEND -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/uart_mem_loader.sv
// UART memory loader: assembles received bytes into 32-bit words and writes
// them to IM/DM (load mode), or reads DM/IM words and streams them out
// LSB-byte-first on the UART transmitter (dump mode). Drives the done LEDs.
module uart_mem_loader #(
  parameter int ADDR_W        = 8,
  parameter int IM_LOAD_WORDS = 10,
  parameter int DM_LOAD_WORDS = 3,
  parameter int DUMP_WORDS    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_on,
  input  logic              uart_mode,
  input  logic              uart_ram_id,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              mem_sel,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              im_done,
  output logic              dm_done,
  output logic              dump_done
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_WRITE    = 4'd2;
  localparam logic [3:0] S_LOAD_END = 4'd3;
  localparam logic [3:0] S_RD       = 4'd4;
  localparam logic [3:0] S_LATCH    = 4'd5;
  localparam logic [3:0] S_SEND     = 4'd6;
  localparam logic [3:0] S_TXWAIT   = 4'd7;
  localparam logic [3:0] S_DUMP_END = 4'd8;

  // Word counts compared one bit wider so a full 2^ADDR_W session is reachable.
  localparam logic [ADDR_W:0] IM_LW  = (ADDR_W+1)'(IM_LOAD_WORDS);
  localparam logic [ADDR_W:0] DM_LW  = (ADDR_W+1)'(DM_LOAD_WORDS);
  localparam logic [ADDR_W:0] DMP_W  = (ADDR_W+1)'(DUMP_WORDS);
  localparam logic [ADDR_W:0] ONE_W  = (ADDR_W+1)'(1);

  logic [3:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic [1:0]        byte_q, byte_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic              im_done_q, im_done_d;
  logic              dm_done_q, dm_done_d;
  logic              dump_done_q, dump_done_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              txs_q, txs_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W:0]   wc_inc;
  logic [ADDR_W:0]   load_words;
  logic [31:0]       rsh;

  assign wc_inc     = {1'b0, wc_q} + ONE_W;
  assign load_words = sel_q ? DM_LW : IM_LW;
  assign rsh        = rdata_q >> {byte_q, 3'b000};

  // Next-state and output-register logic for the load/dump sequencer.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    byte_d      = byte_q;
    wc_d        = wc_q;
    im_done_d   = im_done_q;
    dm_done_d   = dm_done_q;
    dump_done_d = dump_done_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    txs_d       = 1'b0;
    tx_data_d   = tx_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rdata_d     = rdata_q;

    if (!uart_on) begin
      // Session dropped: abandon any partial word, keep done flags.
      state_d = S_IDLE;
      byte_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sel_d  = uart_ram_id;
          wc_d   = '0;
          byte_d = 2'd0;
          if (!uart_mode) begin
            state_d = S_LOAD;
            if (uart_ram_id) dm_done_d = 1'b0;
            else             im_done_d = 1'b0;
          end else begin
            state_d     = S_RD;
            dump_done_d = 1'b0;
            re_d        = 1'b1;
            addr_d      = '0;
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            word_d = {rx_data, word_q[31:8]};
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              wdata_d = {rx_data, word_q[31:8]};
              addr_d  = wc_q;
              we_d    = 1'b1;
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // A byte arriving during the write starts the next word.
          if (rx_valid) begin
            word_d = {rx_data, word_q[31:8]};
            byte_d = byte_q + 2'd1;
          end
          wc_d = wc_inc[ADDR_W-1:0];
          if (wc_inc == load_words) begin
            if (sel_q) dm_done_d = 1'b1;
            else       im_done_d = 1'b1;
            state_d = S_LOAD_END;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_RD: begin
          state_d = S_LATCH;
        end
        S_LATCH: begin
          rdata_d = mem_rdata;
          byte_d  = 2'd0;
          state_d = S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_data_d = rsh[7:0];
            txs_d     = 1'b1;
            state_d   = S_TXWAIT;
          end
        end
        S_TXWAIT: begin
          // tx_busy only rises after the start strobe, so skip the strobe cycle.
          if (!txs_q && !tx_busy) begin
            if (byte_q != 2'd3) begin
              byte_d  = byte_q + 2'd1;
              state_d = S_SEND;
            end else begin
              wc_d = wc_inc[ADDR_W-1:0];
              if (wc_inc == DMP_W) begin
                dump_done_d = 1'b1;
                state_d     = S_DUMP_END;
              end else begin
                re_d    = 1'b1;
                addr_d  = wc_inc[ADDR_W-1:0];
                state_d = S_RD;
              end
            end
          end
        end
        S_LOAD_END, S_DUMP_END: begin
          state_d = state_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state and all visible outputs clear asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      byte_q      <= 2'd0;
      wc_q        <= '0;
      im_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      dump_done_q <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      txs_q       <= 1'b0;
      tx_data_q   <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      byte_q      <= byte_d;
      wc_q        <= wc_d;
      im_done_q   <= im_done_d;
      dm_done_q   <= dm_done_d;
      dump_done_q <= dump_done_d;
      we_q        <= we_d;
      re_q        <= re_d;
      txs_q       <= txs_d;
      tx_data_q   <= tx_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Internal word buffers are only meaningful once filled, so no reset.
  always_ff @(posedge clk) begin
    word_q  <= word_d;
    rdata_q <= rdata_d;
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = txs_q;
  assign mem_sel   = sel_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign im_done   = im_done_q;
  assign dm_done   = dm_done_q;
  assign dump_done = dump_done_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: memory and UART-TX responders, write/TX scoreboards.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_on, uart_mode, uart_ram_id;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start, mem_sel, mem_we, mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        im_done, dm_done, dump_done;

  uart_mem_loader dut (
    .clk(clk), .reset(reset), .uart_on(uart_on), .uart_mode(uart_mode),
    .uart_ram_id(uart_ram_id), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .im_done(im_done),
    .dm_done(dm_done), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  logic [54:0] outs;
  assign outs = {tx_data, tx_start, mem_sel, mem_we, mem_re, mem_addr,
                 mem_wdata, im_done, dm_done, dump_done};

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] bytes;   // first byte sent in [31:24]
    logic [31:0] exp;
    logic        gap;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] txq[$];
  vec_t       vt[10];

  logic [31:0] im_m[256];
  logic [31:0] dm_m[256];
  int          busy_cnt = 0;
  int          tx_cnt = 0;
  logic        prev_we = 1'b0, prev_re = 1'b0, prev_tx = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: synchronous write, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_sel) dm_m[mem_addr] <= mem_wdata;
      else         im_m[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem_sel ? dm_m[mem_addr] : im_m[mem_addr];
  end

  // UART-TX responder: busy rises the cycle after tx_start, lasts a few cycles.
  always @(posedge clk) begin
    if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 6;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  // Output monitor: pops the scoreboards on every strobe.
  always @(negedge clk) begin
    if (mem_we | mem_re | tx_start)
      chk("strobe_excl", 64'(mem_we) + 64'(mem_re) + 64'(tx_start), 64'd1);
    if (mem_we) begin
      chk("we_pulse", prev_we, 1'b0);
      if (wq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: sel %0d addr %0h data %0h, none expected",
                 mem_sel, mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_sel", mem_sel, e.sel);
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
    if (mem_re) chk("re_pulse", prev_re, 1'b0);
    if (tx_start) begin
      chk("tx_pulse", prev_tx, 1'b0);
      chk("tx_while_busy", tx_busy, 1'b0);
      tx_cnt <= tx_cnt + 1;
      if (txq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_tx: byte %0h, none expected", tx_data);
      end else begin
        chk("tx_byte", tx_data, txq.pop_front());
      end
    end
    prev_we <= mem_we;
    prev_re <= mem_re;
    prev_tx <= tx_start;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // gap=0 leaves rx_valid high after the last byte so the next word can follow at once.
  task automatic send_word(input logic [31:0] b, input logic gap);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      rx_data  = b[31-8*j -: 8];
      rx_valid = 1'b1;
      if (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    logic seen;

    vt[0] = '{32'h0A000820, 32'h2008000A, 1'b0};
    vt[1] = '{32'h11223344, 32'h44332211, 1'b1};
    vt[2] = '{32'hFF00FF00, 32'h00FF00FF, 1'b0};
    vt[3] = '{32'h01020304, 32'h04030201, 1'b1};
    vt[4] = '{32'hDEADBEEF, 32'hEFBEADDE, 1'b0};
    vt[5] = '{32'h00000080, 32'h80000000, 1'b1};
    vt[6] = '{32'h7FFFFFFF, 32'hFFFFFF7F, 1'b0};
    vt[7] = '{32'h55AA55AA, 32'hAA55AA55, 1'b1};
    vt[8] = '{32'h13000000, 32'h00000013, 1'b0};
    vt[9] = '{32'h93015000, 32'h00500193, 1'b1};

    reset = 1'b0; uart_on = 1'b0; uart_mode = 1'b0; uart_ram_id = 1'b0;
    rx_data = 8'd0; rx_valid = 1'b0;
    wait_cyc(3);
    chk("reset_outs", outs, 55'd0);
    reset = 1'b1;
    wait_cyc(2);
    chk("idle_outs", outs, 55'd0);

    // IM load of 10 words, ram_id toggled mid-session (must stay IM).
    uart_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      uart_ram_id = (i >= 3 && i <= 5);
      wq.push_back('{1'b0, 8'(i), vt[i].exp});
      send_word(vt[i].bytes, vt[i].gap);
      if (i == 8) chk("im_done_early", im_done, 1'b0);
    end
    uart_ram_id = 1'b0;
    @(negedge clk); rx_valid = 1'b0;
    wait_cyc(4);
    chk("im_done_set", im_done, 1'b1);
    chk("dm_done_clear", dm_done, 1'b0);
    chk("im_writes_left", wq.size(), 0);
    send_word(32'h01020304, 1'b1);   // 11th word must not be written
    wait_cyc(4);
    chk("im_done_hold", im_done, 1'b1);
    uart_on = 1'b0;
    wait_cyc(2);

    // DM load with a discarded partial word.
    uart_ram_id = 1'b1;
    uart_on = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    uart_on = 1'b0;
    wait_cyc(2);
    uart_on = 1'b1;
    wq.push_back('{1'b1, 8'd0, 32'h12345678});
    send_word(32'h78563412, 1'b1);
    wait_cyc(3);
    chk("dm_done_early", dm_done, 1'b0);
    chk("dm_first_write", wq.size(), 0);
    wq.push_back('{1'b1, 8'd1, 32'hCAFEF00D});
    send_word(32'h0DF0FECA, 1'b0);
    wq.push_back('{1'b1, 8'd2, 32'h00FF0180});
    send_word(32'h8001FF00, 1'b1);
    wait_cyc(4);
    chk("dm_done_set", dm_done, 1'b1);
    chk("im_done_kept", im_done, 1'b1);
    chk("dm_writes_left", wq.size(), 0);
    uart_on = 1'b0;
    wait_cyc(2);

    // Dump DM: 3 words, LSB byte first.
    uart_mode = 1'b1;
    foreach (vt[k]) if (k < 0) txq.push_back(8'h00);
    txq.push_back(8'h78); txq.push_back(8'h56); txq.push_back(8'h34); txq.push_back(8'h12);
    txq.push_back(8'h0D); txq.push_back(8'hF0); txq.push_back(8'hFE); txq.push_back(8'hCA);
    txq.push_back(8'h80); txq.push_back(8'h01); txq.push_back(8'hFF); txq.push_back(8'h00);
    base = tx_cnt;
    uart_on = 1'b1;
    for (int k = 0; k < 3000 && !dump_done; k++) @(negedge clk);
    chk("dump_done_set", dump_done, 1'b1);
    chk("dump_bytes_left", txq.size(), 0);
    chk("dump_byte_count", tx_cnt - base, 12);
    wait_cyc(20);
    chk("dump_end_quiet", tx_cnt - base, 12);
    chk("dump_done_hold", dump_done, 1'b1);
    uart_on = 1'b0;
    wait_cyc(2);

    // Reset while a write strobe is out.
    uart_mode = 1'b0; uart_ram_id = 1'b0;
    uart_on = 1'b1;
    @(negedge clk);
    send_word(32'h01020304, 1'b0);
    @(posedge clk); #1;
    chk("we_before_rst", mem_we, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid_write_outs", outs, 55'd0);
    rx_valid = 1'b0; uart_on = 1'b0;
    @(negedge clk); reset = 1'b1;
    wait_cyc(2);
    chk("after_rst_idle", outs, 55'd0);

    // Reset while transmitting.
    uart_mode = 1'b1; uart_ram_id = 1'b1;
    txq.push_back(8'h78);
    uart_on = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = tx_start;
    end
    chk("tx_seen", seen, 1'b1);
    @(posedge clk); #1;
    chk("tx_data_before_rst", tx_data, 8'h78);
    reset = 1'b0;
    #1;
    chk("rst_mid_send_outs", outs, 55'd0);
    uart_on = 1'b0;
    @(negedge clk); reset = 1'b1;
    wait_cyc(10);
    chk("final_idle", outs, 55'd0);
    chk("tx_left", txq.size(), 0);
    chk("wr_left", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
